// File: rtl/divider_pipelined.sv
// rtl/divider_pipelined.sv - fully pipelined unsigned restoring divider, one quotient bit per stage
module divider_pipelined #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic             out_valid,
  output logic [width-1:0] q,
  output logic [width-1:0] r,
  output logic             div_by_zero
);

  // Stage 0 is the input register; stage width drives the outputs.
  logic             r_valid [0:width];
  logic             r_dz    [0:width];
  logic [width-1:0] r_rem   [0:width];
  logic [width-1:0] r_q     [0:width];
  logic [width-1:0] r_a     [0:width-1];
  logic [width-1:0] r_b     [0:width-1];

  logic [width:0]   w_trial [1:width];
  logic             w_ge    [1:width];
  logic [width-1:0] w_rem   [1:width];

  always_comb begin
    for (int k = 1; k <= width; k++) begin
      w_trial[k] = {r_rem[k-1], r_a[k-1][width-k]};
      w_ge[k]    = (w_trial[k] >= {1'b0, r_b[k-1]});
      // The true difference is below b, so the low width bits are exact.
      w_rem[k]   = w_ge[k] ? (w_trial[k][width-1:0] - r_b[k-1])
                           : w_trial[k][width-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= width; k++) begin
        r_valid[k] <= 1'b0;
        r_dz[k]    <= 1'b0;
        r_rem[k]   <= '0;
        r_q[k]     <= '0;
      end
      for (int k = 0; k < width; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
      end
    end else begin
      r_valid[0] <= in_valid;
      r_a[0]     <= a;
      r_b[0]     <= b;
      r_dz[0]    <= (b == '0);
      r_rem[0]   <= '0;
      r_q[0]     <= '0;
      for (int k = 1; k <= width; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_dz[k]    <= r_dz[k-1];
        r_rem[k]   <= w_rem[k];
        r_q[k]     <= {r_q[k-1][width-2:0], w_ge[k]};
      end
      for (int k = 1; k < width; k++) begin
        r_a[k] <= r_a[k-1];
        r_b[k] <= r_b[k-1];
      end
    end
  end

  assign out_valid   = r_valid[width];
  assign q           = r_q[width];
  assign r           = r_rem[width];
  assign div_by_zero = r_dz[width];

endmodule

// File: tb/tb_divider_pipelined.sv
// tb/tb_divider_pipelined.sv - scoreboard bench for divider_pipelined with directed vectors
module tb_divider_pipelined;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         div_by_zero;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_chk = 0;

  divider_pipelined #(.width(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(out_valid), .q(q), .r(r), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, act, req);
  endtask

  // Issue one operation; the result is due at the falling edge after W more rising edges.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input bit track,
                      input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    exp_t e;
    in_valid = 1'b1;
    a = ta;
    b = tb_v;
    @(posedge clk);
    #1;
    if (track) begin
      e.q = eq; e.r = er; e.dz = edz; e.due = cyc + W;
      sb.push_back(e);
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        n_chk++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_out: cycle %0d q=%0d r=%0d dz=%0d, want no result", cyc, q, r, div_by_zero);
        end else begin
          mon_e = sb.pop_front();
          if (q === mon_e.q && r === mon_e.r && div_by_zero === mon_e.dz && cyc == mon_e.due)
            n_pass++;
          else
            $display("FAIL result: cycle %0d q=%0d r=%0d dz=%0d, want cycle %0d q=%0d r=%0d dz=%0d",
                     cyc, q, r, div_by_zero, mon_e.due, mon_e.q, mon_e.r, mon_e.dz);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        n_chk++;
        mon_e = sb.pop_front();
        $display("FAIL missing_out: cycle %0d no out_valid, want q=%0d r=%0d due %0d",
                 cyc, mon_e.q, mon_e.r, mon_e.due);
      end
    end
  end

  initial begin
    logic [W-1:0] ra, rb;
    int wait_n;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_q", {24'd0, q}, 32'd0);
    check("reset_r", {24'd0, r}, 32'd0);
    check("reset_dz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    idle(1);

    send(8'd100, 8'd7, 1'b1, 8'd14, 8'd2, 1'b0);
    idle(W + 2);

    send(8'd255, 8'd1, 1'b1, 8'd255, 8'd0, 1'b0);
    send(8'd0, 8'd5, 1'b1, 8'd0, 8'd0, 1'b0);
    send(8'd5, 8'd9, 1'b1, 8'd0, 8'd5, 1'b0);
    send(8'd255, 8'd255, 1'b1, 8'd1, 8'd0, 1'b0);
    idle(W + 2);

    send(8'd77, 8'd0, 1'b1, 8'd255, 8'd77, 1'b1);
    send(8'd10, 8'd3, 1'b1, 8'd3, 8'd1, 1'b0);
    idle(W + 2);

    send(8'd50, 8'd6, 1'b1, 8'd8, 8'd2, 1'b0);
    idle(1);
    send(8'd9, 8'd4, 1'b1, 8'd2, 8'd1, 1'b0);
    send(8'd128, 8'd16, 1'b1, 8'd8, 8'd0, 1'b0);
    idle(W + 2);

    // Five operations in flight, then an asynchronous reset pulse between edges.
    send(8'd20, 8'd3, 1'b0, 8'd0, 8'd0, 1'b0);
    send(8'd40, 8'd7, 1'b0, 8'd0, 8'd0, 1'b0);
    send(8'd60, 8'd0, 1'b0, 8'd0, 8'd0, 1'b0);
    send(8'd80, 8'd9, 1'b0, 8'd0, 8'd0, 1'b0);
    send(8'd99, 8'd2, 1'b0, 8'd0, 8'd0, 1'b0);
    idle(2);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    check("midreset_q", {24'd0, q}, 32'd0);
    check("midreset_r", {24'd0, r}, 32'd0);
    check("midreset_dz", {31'd0, div_by_zero}, 32'd0);
    #1 rst_n = 1'b1;
    idle(W + 4);
    send(8'd200, 8'd13, 1'b1, 8'd15, 8'd5, 1'b0);
    idle(W + 2);

    for (int i = 0; i < 300; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = ($urandom_range(0, 99) < 5) ? '0 : W'($urandom_range(1, 255));
      if (rb == '0) send(ra, rb, 1'b1, '1, ra, 1'b1);
      else          send(ra, rb, 1'b1, ra / rb, ra % rb, 1'b0);
    end

    wait_n = 0;
    while (sb.size() > 0 && wait_n < 4 * W) begin
      idle(1);
      wait_n++;
    end
    idle(2);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
